// File: rtl/mmcm_ctrl_pkg.sv
// Shared definitions for the MMCM input-select control slice.
//   mmcm_state_e : sequencer states (reset hold, select switch, lock wait,
//                  locked, failed).
//   cnt_width()  : bits needed to hold a counter value 0..max_val.
//   max3()       : largest of three integers, used to size shared counters.
package mmcm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_SWITCH    = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } mmcm_state_e;

    function automatic int cnt_width(input int max_val);
        if (max_val < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous status bit.
//   clk   : destination clock
//   reset : synchronous, active-low; clears every stage to 0
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module sync_bit #(
    parameter int STAGES = 32'sd2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 32'sd1) begin : g_bad_stages
        $error("sync_bit: STAGES must be at least 1");
    end

    logic [STAGES-1:0] sync_r;

    // Shift chain: new sample enters at bit 0, q taken from the top bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= (sync_r << 1) | STAGES'(d);
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/mmcm_clksel_sequencer.sv
// Reset/CLKINSEL sequencer for one MMCME2_ADV with two reference inputs.
// Holds MMCM RST high around every CLKINSEL update, qualifies LOCKED,
// retries on lock timeout and optionally re-locks after lock loss.
//   clk, reset        : free-running control clock, sync active-low reset
//   req_valid/req_sel : request to re-run the sequence with a new select
//   req_ready         : high in LOCKED and FAIL only
//   mmcm_rst          : MMCM RST
//   mmcm_clkinsel     : MMCM CLKINSEL
//   mmcm_locked       : raw MMCM LOCKED (asynchronous)
//   locked, busy      : qualified lock / sequence in progress
//   done, lock_lost   : one-cycle pulses on lock declared / lock dropped
//   err_timeout       : high while in FAIL
//   retry_cnt         : timeouts retried in the current sequence
module mmcm_clksel_sequencer
    import mmcm_ctrl_pkg::*;
#(
    parameter logic DEFAULT_SEL         = 1'b0,
    parameter int   RST_HOLD_CYCLES     = 32'sd16,
    parameter int   SEL_SETUP_CYCLES    = 32'sd4,
    parameter int   LOCK_TIMEOUT_CYCLES = 32'sd65535,
    parameter int   LOCK_STABLE_CYCLES  = 32'sd8,
    parameter int   MAX_RETRIES         = 32'sd3,
    parameter bit   AUTO_RELOCK         = 1'b1,
    parameter int   SYNC_STAGES         = 32'sd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    output logic       mmcm_rst,
    output logic       mmcm_clkinsel,
    input  logic       mmcm_locked,
    output logic       locked,
    output logic       busy,
    output logic       done,
    output logic       lock_lost,
    output logic       err_timeout,
    output logic [1:0] retry_cnt
);

    if ((MAX_RETRIES > 32'sd3) || (MAX_RETRIES < 32'sd0) ||
        (RST_HOLD_CYCLES < 32'sd1) || (SEL_SETUP_CYCLES < 32'sd1) ||
        (LOCK_TIMEOUT_CYCLES < 32'sd1) || (LOCK_STABLE_CYCLES < 32'sd1)) begin : g_bad_params
        $error("mmcm_clksel_sequencer: parameter out of range");
    end

    // One phase counter serves hold, setup and timeout since only one runs at a time.
    localparam int CW = cnt_width(max3(RST_HOLD_CYCLES, SEL_SETUP_CYCLES, LOCK_TIMEOUT_CYCLES));
    localparam int SW = cnt_width(LOCK_STABLE_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 32'sd1);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SEL_SETUP_CYCLES - 32'sd1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 32'sd1);
    localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 32'sd1);
    localparam logic [SW-1:0] STABLE_SAT  = {SW{1'b1}};
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    mmcm_state_e state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic [SW-1:0] stable_r, stable_s, stable_inc_s;
    logic [1:0]    retry_r, retry_s;
    logic          target_r, target_s;
    logic          lk_s;
    logic          accept_s, lock_drop_s;
    logic          rst_o_s, sel_o_s, locked_o_s, busy_o_s, ready_o_s;
    logic          done_o_s, lost_o_s, err_o_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (lk_s)
    );

    assign cnt_inc_s    = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CW'(1'b1);
    assign stable_inc_s = (stable_r == STABLE_SAT) ? stable_r : stable_r + SW'(1'b1);
    assign accept_s     = req_valid && req_ready;
    // A drop is only reported once: locked stays low afterwards.
    assign lock_drop_s  = (state_r == ST_LOCKED) && locked && !lk_s;
    assign retry_cnt    = retry_r;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_RST_HOLD;
            cnt_r         <= {CW{1'b0}};
            stable_r      <= {SW{1'b0}};
            retry_r       <= 2'd0;
            target_r      <= DEFAULT_SEL;
            mmcm_rst      <= 1'b1;
            mmcm_clkinsel <= DEFAULT_SEL;
            locked        <= 1'b0;
            busy          <= 1'b1;
            req_ready     <= 1'b0;
            done          <= 1'b0;
            lock_lost     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            stable_r      <= stable_s;
            retry_r       <= retry_s;
            target_r      <= target_s;
            mmcm_rst      <= rst_o_s;
            mmcm_clkinsel <= sel_o_s;
            locked        <= locked_o_s;
            busy          <= busy_o_s;
            req_ready     <= ready_o_s;
            done          <= done_o_s;
            lock_lost     <= lost_o_s;
            err_timeout   <= err_o_s;
        end
    end

    // Next-state, counter and target selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        stable_s = stable_r;
        retry_s  = retry_r;
        target_s = target_r;
        case (state_r)
            ST_RST_HOLD: begin
                if (cnt_r >= HOLD_LAST) begin
                    state_s = ST_SWITCH;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_SWITCH: begin
                if (cnt_r >= SETUP_LAST) begin
                    state_s  = ST_WAIT_LOCK;
                    cnt_s    = {CW{1'b0}};
                    stable_s = {SW{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    stable_s = stable_inc_s;
                end else begin
                    stable_s = {SW{1'b0}};
                end
                // A completed stability run wins over a timeout in the same cycle.
                if (lk_s && (stable_r >= STABLE_LAST)) begin
                    state_s  = ST_LOCKED;
                    retry_s  = 2'd0;
                    cnt_s    = {CW{1'b0}};
                    stable_s = {SW{1'b0}};
                end else if (cnt_r >= TMO_LAST) begin
                    cnt_s    = {CW{1'b0}};
                    stable_s = {SW{1'b0}};
                    if (retry_r < RETRY_MAX) begin
                        retry_s = retry_r + 2'd1;
                        state_s = ST_RST_HOLD;
                    end else begin
                        state_s = ST_FAIL;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_LOCKED, ST_FAIL: begin
                if (accept_s) begin
                    state_s  = ST_RST_HOLD;
                    target_s = req_sel;
                    retry_s  = 2'd0;
                    cnt_s    = {CW{1'b0}};
                end else if (AUTO_RELOCK && lock_drop_s) begin
                    state_s = ST_RST_HOLD;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_RST_HOLD;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output values for the next cycle, derived from the upcoming state.
    always_comb begin
        rst_o_s    = 1'b1;
        sel_o_s    = mmcm_clkinsel;
        locked_o_s = 1'b0;
        busy_o_s   = 1'b1;
        ready_o_s  = 1'b0;
        done_o_s   = 1'b0;
        err_o_s    = 1'b0;
        lost_o_s   = lock_drop_s;
        case (state_s)
            ST_RST_HOLD: begin
                rst_o_s = 1'b1;
            end
            ST_SWITCH: begin
                // CLKINSEL moves only on SWITCH entry, after the full RST hold.
                if (state_r != ST_SWITCH) begin
                    sel_o_s = target_r;
                end else begin
                    sel_o_s = mmcm_clkinsel;
                end
            end
            ST_WAIT_LOCK: begin
                rst_o_s = 1'b0;
            end
            ST_LOCKED: begin
                rst_o_s   = 1'b0;
                busy_o_s  = 1'b0;
                ready_o_s = 1'b1;
                if (state_r == ST_LOCKED) begin
                    locked_o_s = locked && lk_s;
                end else begin
                    locked_o_s = 1'b1;
                    done_o_s   = 1'b1;
                end
            end
            ST_FAIL: begin
                busy_o_s  = 1'b0;
                ready_o_s = 1'b1;
                err_o_s   = 1'b1;
            end
            default: begin
                rst_o_s = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmcm_clksel_sequencer.sv
// Directed bench for mmcm_clksel_sequencer with a simple MMCM model:
// LOCKED rises MDL_LOCK clk cycles after RST falls, and CLKOUT follows the
// selected reference (CLKIN1 100 MHz, CLKIN2 125 MHz) while locked.
// The lock timeout is shortened so the retry/FAIL path fits the cycle budget.
module tb_mmcm_clksel_sequencer;

    localparam int HOLD     = 16;
    localparam int SETUP    = 4;
    localparam int TMO      = 100;
    localparam int MDL_LOCK = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_sel = 1'b0;
    logic       req_ready, mmcm_rst, mmcm_clkinsel, mmcm_locked;
    logic       locked, busy, done, lock_lost, err_timeout;
    logic [1:0] retry_cnt;
    logic       clkin1 = 1'b0;
    logic       clkin2 = 1'b0;
    logic       mdl_locked, clkout;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int lk_mode = 0;      // 0: model, 1: forced low, 2: forced high
    int mdl_cnt = 0;
    int clkout_edges = 0;
    int inv_err = 0;
    int rst_run = 0;
    int setup_left = 0;
    logic prev_sel = 1'bx;
    int c0;

    mmcm_clksel_sequencer #(
        .DEFAULT_SEL(1'b0), .RST_HOLD_CYCLES(HOLD), .SEL_SETUP_CYCLES(SETUP),
        .LOCK_TIMEOUT_CYCLES(TMO), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(3),
        .AUTO_RELOCK(1'b1), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .mmcm_rst(mmcm_rst), .mmcm_clkinsel(mmcm_clkinsel),
        .mmcm_locked(mmcm_locked), .locked(locked), .busy(busy), .done(done),
        .lock_lost(lock_lost), .err_timeout(err_timeout), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;
    initial begin #2; forever #5 clkin1 = ~clkin1; end
    initial begin #1; forever #4 clkin2 = ~clkin2; end

    // MMCM model: lock counter restarts whenever RST is high.
    always @(posedge clk) begin
        if (mmcm_rst !== 1'b0) mdl_cnt <= 0;
        else if (mdl_cnt < MDL_LOCK) mdl_cnt <= mdl_cnt + 1;
    end
    assign mdl_locked  = (mdl_cnt == MDL_LOCK) && (mmcm_rst === 1'b0);
    assign mmcm_locked = (lk_mode == 0) ? mdl_locked : (lk_mode == 2);
    assign clkout      = mdl_locked & (mmcm_clkinsel ? clkin2 : clkin1);

    always @(posedge clkout) clkout_edges = clkout_edges + 1;

    // Select-change safety monitor, sampled mid-cycle on every cycle.
    always @(negedge clk) begin
        if (!$isunknown(prev_sel) && (mmcm_clkinsel !== prev_sel)) begin
            if (rst_run < HOLD) inv_err = inv_err + 1;
            setup_left = SETUP;
        end
        if (setup_left > 0) begin
            if (mmcm_rst !== 1'b1) inv_err = inv_err + 1;
            setup_left = setup_left - 1;
        end
        rst_run  = (mmcm_rst === 1'b1) ? rst_run + 1 : 0;
        prev_sel = mmcm_clkinsel;
    end

    function automatic logic [31:0] outs();
        return {22'd0, mmcm_rst, mmcm_clkinsel, locked, busy, req_ready,
                done, lock_lost, err_timeout, retry_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values (outs: rst,sel,locked,busy,ready,done,lost,err,retry[1:0])
        step(3);
        check("reset_outs", outs(), 32'h240);
        reset = 1'b1;

        // Bring-up: RST falls at edge 20, model locks at 30, locked at 40.
        step(19);
        check("bringup_rst_e19", 32'(mmcm_rst), 32'd1);
        step(1);
        check("bringup_rst_fall_e20", outs(), 32'h040);
        step(19);
        check("bringup_locked_e39", 32'(locked), 32'd0);
        step(1);
        check("bringup_locked_e40", outs(), 32'h0B0);
        step(1);
        check("bringup_done_once", outs(), 32'h0A0);
        c0 = clkout_edges;
        #2000;
        check("freq_clkin1", 32'(clkout_edges - c0), 32'd200);

        // Switch to CLKIN2; then hold a request high while busy.
        req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        check("switch_accept", outs(), 32'h240);
        req_sel = 1'b0;
        step(1);
        check("busy_ready_low_hold", 32'(req_ready), 32'd0);
        step(14);
        check("switch_sel_e15", 32'(mmcm_clkinsel), 32'd0);
        step(1);
        check("switch_sel_e16", 32'(mmcm_clkinsel), 32'd1);
        step(3);
        check("switch_rst_e19", 32'(mmcm_rst), 32'd1);
        step(1);
        check("switch_rst_fall_e20", outs(), 32'h140);
        step(5);
        check("busy_ready_low_wait", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        step(15);
        check("switch_relock_e40", outs(), 32'h1B0);
        c0 = clkout_edges;
        #2000;
        check("freq_clkin2", 32'(clkout_edges - c0), 32'd250);

        // One-cycle lock drop with auto re-lock on the same select.
        lk_mode = 1;
        step(1);
        lk_mode = 0;
        step(1);
        check("drop_sync_delay", 32'(locked), 32'd1);
        step(1);
        check("drop_lock_lost", outs(), 32'h348);
        step(1);
        check("drop_lost_once", 32'(lock_lost), 32'd0);
        step(38);
        check("drop_relock_e42", 32'(locked), 32'd0);
        step(1);
        check("drop_relock_e43", outs(), 32'h1B0);

        // Forced re-lock with a 5-cycle LOCKED glitch in WAIT_LOCK.
        lk_mode = 1; req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("same_sel_accept", outs(), 32'h340);
        step(22);
        lk_mode = 2;
        step(5);
        lk_mode = 1;
        step(5);
        check("glitch_no_lock", 32'(locked), 32'd0);
        lk_mode = 2;
        step(5);
        check("stable_restart_e37", 32'(locked), 32'd0);
        step(4);
        check("stable_restart_e41", 32'(locked), 32'd0);
        step(1);
        check("stable_restart_e42", 32'(locked), 32'd1);

        // Lock never arrives: 3 retries then FAIL.
        lk_mode = 1; req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        step(119);
        check("retry0_before_tmo", 32'({mmcm_rst, retry_cnt}), 32'd0);
        step(1);
        check("retry1", 32'({mmcm_rst, retry_cnt}), 32'd5);
        step(240);
        check("retry3", 32'({mmcm_rst, retry_cnt}), 32'd7);
        step(119);
        check("last_attempt", outs(), 32'h143);
        step(1);
        check("fail_state", outs(), 32'h327);
        step(5);
        check("fail_sticky", 32'(err_timeout), 32'd1);

        // Request out of FAIL clears the error; reset mid-SWITCH aborts.
        lk_mode = 0; req_valid = 1'b1; req_sel = 1'b1;
        step(1);
        req_valid = 1'b0;
        check("fail_recover", outs(), 32'h340);
        step(17);
        check("abort_in_switch", outs(), 32'h340);
        reset = 1'b0;
        step(1);
        check("abort_reset_outs", outs(), 32'h240);
        step(3);
        reset = 1'b1;
        step(40);
        check("rebringup_locked", outs(), 32'h0B0);

        check("invariant_violations", 32'(inv_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
